mc_mem_responder: RTL and testbench
===================================

Name: mc_mem_responder

Overview:
- Shared instruction/data memory that answers the multicycle controller's memory requests (MemRead, MemWrite, IorD-selected address).
- Sits on the datapath side, opposite the control unit. Accepts one request at a time and inserts a configurable number of wait states.
- Returns a one-cycle MemReady pulse, with ReadData or MemError, so the controller can stall the IF/Lw/SW states until the access completes.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words. Power of two, at least 4.
- WAIT_CYCLES, 2, extra wait states between acceptance and response. Range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset. rst=0 resets immediately, regardless of clk.
- MemRead  input  1  read request. Held by controller until MemReady.
- MemWrite  input  1  write request. Held by controller until MemReady.
- Adr  input  32  byte address. Adr[1:0] must be 00.
- WriteData  input  32  store data, valid with MemWrite.
- ReadData  output  32  registered read data.
- MemReady  output  1  one-cycle completion pulse.
- MemError  output  1  high together with MemReady when the access was rejected.
- Busy  output  1  high in BUSY and RESP states.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0.
  - ReadData=0, MemReady=0, MemError=0, Busy=0.
  - Latched address and data are cleared.
  - Storage array is not reset.
  - Reset mid-access aborts the access; no write occurs.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - On a rising edge with MemRead=1 or MemWrite=1, latch Adr, WriteData and the request type. Load counter=WAIT_CYCLES and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Inputs are ignored; latched values are used.
  - If counter != 0, decrement and stay in BUSY.
  - If counter == 0, perform the access on this edge and go to RESP.
- Performing the access:
  - Word index is the latched Adr[log2(DEPTH_WORDS)+1:2].
  - Error if any of the following holds:
    - latched Adr[1:0] != 00;
    - latched Adr >= 4*DEPTH_WORDS;
    - MemRead and MemWrite were both 1 at acceptance.
  - On error: no write, ReadData unchanged, MemError=1.
  - Valid read: ReadData <= mem[index].
  - Valid write: mem[index] <= WriteData, ReadData unchanged.
- RESP:
  - MemReady=1 (and MemError as computed) for exactly one cycle.
  - Next edge returns to IDLE; MemReady and MemError return to 0.
- Latency: MemReady is high in the cycle following edge t0+WAIT_CYCLES+1, where t0 is the accepting edge. WAIT_CYCLES=0 gives MemReady one cycle after acceptance.
- Back-to-back: the controller drops its request in the MemReady cycle.
  - A request still high at the RESP->IDLE edge is not sampled. Acceptance occurs only in IDLE.
  - A request still high in the following IDLE cycle is treated as a new request.
- ReadData holds its value until the next successful read. It is not cleared by writes or errors.
- A request that deasserts before MemReady (protocol violation) does not abort the access; the access completes from latched values.
- Busy = (state != IDLE).

Test Plan:
- Reset and idle:
  - Assert rst=0 mid-BUSY of a write to 0x10 with WAIT_CYCLES=2.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - After release, a read of 0x10 shows the old contents (write aborted).
- Write then read, WAIT_CYCLES=2:
  - MemWrite Adr=0x20 WriteData=0xDEADBEEF, then MemRead Adr=0x20.
  - Required: each MemReady appears 3 edges after acceptance; ReadData=0xDEADBEEF; MemError=0.
- Zero wait, WAIT_CYCLES=0:
  - Three consecutive reads of 0x0, 0x4, 0x8, each dropped on MemReady.
  - Required: MemReady one cycle after each accept; an IDLE cycle between responses; correct data each time.
- Errors:
  - Read Adr=0x22 (misaligned), read Adr=4*DEPTH_WORDS, and MemRead=MemWrite=1 at 0x30.
  - Required: MemReady=1 with MemError=1 in each case; ReadData holds its prior value; mem[0x30>>2] unchanged.
- Input changes during BUSY:
  - Accept a read of 0x40, then change Adr to 0x44 and raise MemWrite while in BUSY.
  - Required: returns mem[0x40]; no write occurs.
- Request held past MemReady:
  - Keep MemRead high for 2 extra cycles after MemReady.
  - Required: exactly one additional access is accepted, in the IDLE cycle after RESP.

Source files
------------

// File: rtl/mc_mem_responder.sv
// Shared instruction/data memory for the multicycle controller: accepts one
// request at a time, inserts WAIT_CYCLES wait states, then pulses MemReady.
module mc_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemError,
  output logic        Busy
);

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_adr;
  logic [31:0] r_wdata;
  logic        r_rd;
  logic        r_wr;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_access;
  logic          w_err;
  logic [AW-1:0] w_idx;

  assign w_accept = (r_state == IDLE) && (MemRead || MemWrite);
  assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);
  assign w_idx    = r_adr[AW+1:2];
  // Misaligned, beyond the array, or an ambiguous read+write request.
  assign w_err    = (r_adr[1:0] != 2'b00) || (r_adr[31:AW+2] != '0) || (r_rd && r_wr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves w_next unassigned (no latch).
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = BUSY;
      BUSY:    if (w_access) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= 4'd0;
      r_adr    <= 32'd0;
      r_wdata  <= 32'd0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_err    <= 1'b0;
      ReadData <= 32'd0;
    end else begin
      if (w_accept) begin
        r_adr   <= Adr;
        r_wdata <= WriteData;
        r_rd    <= MemRead;
        r_wr    <= MemWrite;
        r_cnt   <= WAIT_LD;
      end else if (r_state == BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_err <= w_err;
        if (!w_err && r_rd) ReadData <= r_mem[w_idx];
      end
    end
  end

  // NOTE: the storage array has no reset; a reset during BUSY already forces IDLE, so no write can fire.
  always_ff @(posedge clk) begin
    if (w_access && !w_err && r_wr) r_mem[w_idx] <= r_wdata;
  end

  assign MemReady = (r_state == RESP);
  assign MemError = MemReady && r_err;
  assign Busy     = (r_state != IDLE);

endmodule

// File: tb/tb_mc_mem_responder.sv
// Bench for mc_mem_responder: one instance with two wait states, one with none,
// directed scenarios plus random traffic checked against an array-based model.
module tb_mc_mem_responder;

  localparam int DEPTH = 256;
  localparam int WAITS [2] = '{2, 0};

  logic        clk;
  logic        rst;
  logic        rd_i   [2];
  logic        wr_i   [2];
  logic [31:0] adr_i  [2];
  logic [31:0] wd_i   [2];
  logic [31:0] rdat_o [2];
  logic        rdy_o  [2];
  logic        err_o  [2];
  logic        busy_o [2];

  int vectors;
  int miscompares;

  logic [31:0] mdl_mem [2][DEPTH];
  logic [31:0] mdl_rd  [2];

  mc_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst), .MemRead(rd_i[0]), .MemWrite(wr_i[0]), .Adr(adr_i[0]),
    .WriteData(wd_i[0]), .ReadData(rdat_o[0]), .MemReady(rdy_o[0]),
    .MemError(err_o[0]), .Busy(busy_o[0])
  );

  mc_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .MemRead(rd_i[1]), .MemWrite(wr_i[1]), .Adr(adr_i[1]),
    .WriteData(wd_i[1]), .ReadData(rdat_o[1]), .MemReady(rdy_o[1]),
    .MemError(err_o[1]), .Busy(busy_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one completed access, straight from the address rules.
  function automatic logic model_access(input int d, input bit rd, input bit wr,
                                        input logic [31:0] adr, input logic [31:0] wd);
    logic err;
    int   idx;
    err = (adr[1:0] != 2'b00) || (adr >= 32'(4 * DEPTH)) || (rd && wr);
    idx = int'(adr >> 2);
    if (!err) begin
      if (wr) mdl_mem[d][idx] = wd;
      if (rd) mdl_rd[d] = mdl_mem[d][idx];
    end
    return err;
  endfunction

  // One full handshake: drive, accept, wait for MemReady, check, drop, check the IDLE cycle.
  // tamper changes Adr/MemWrite while the access is in BUSY.
  task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] adr,
                        input logic [31:0] wd, input bit tamper, input string tag);
    logic exp_err;
    int   k;
    exp_err = model_access(d, rd, wr, adr, wd);
    @(negedge clk);
    rd_i[d] = rd; wr_i[d] = wr; adr_i[d] = adr; wd_i[d] = wd;
    @(posedge clk); #1;
    check({tag, " busy_after_accept"}, 32'(busy_o[d]), 32'd1);
    if (tamper) begin
      @(negedge clk);
      adr_i[d] = adr + 32'd4; wr_i[d] = 1'b1; wd_i[d] = 32'hBAD0_BAD0;
    end
    k = 0;
    while (!rdy_o[d] && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'(WAITS[d] + 1));
    check({tag, " err"}, 32'(err_o[d]), 32'(exp_err));
    check({tag, " rdata"}, rdat_o[d], mdl_rd[d]);
    rd_i[d] = 1'b0; wr_i[d] = 1'b0;
    @(posedge clk); #1;
    check({tag, " ready_dropped"}, {30'd0, rdy_o[d], busy_o[d]}, 32'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int d = 0; d < 2; d++) begin
      rd_i[d] = 1'b0; wr_i[d] = 1'b0; adr_i[d] = '0; wd_i[d] = '0; mdl_rd[d] = '0;
    end
    rst = 1'b0;
    #23;
    for (int d = 0; d < 2; d++)
      check("reset_outputs", rdat_o[d] | {29'd0, rdy_o[d], err_o[d], busy_o[d]}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Give the first 32 words of both instances known contents.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++)
        access(d, 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0, "init_wr");

    // Asynchronous reset in the middle of a write to 0x10.
    @(negedge clk);
    wr_i[0] = 1'b1; adr_i[0] = 32'h10; wd_i[0] = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("async_reset_rdata", rdat_o[0], 32'd0);
    check("async_reset_flags", {29'd0, rdy_o[0], err_o[0], busy_o[0]}, 32'd0);
    wr_i[0] = 1'b0;
    mdl_rd[0] = '0; mdl_rd[1] = '0;
    @(negedge clk); @(negedge clk); rst = 1'b1;
    access(0, 1'b1, 1'b0, 32'h10, '0, 1'b0, "read_after_abort");

    access(0, 1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 1'b0, "wr_20");
    access(0, 1'b1, 1'b0, 32'h20, '0, 1'b0, "rd_20");
    check("rd_20_value", rdat_o[0], 32'hDEAD_BEEF);

    access(1, 1'b1, 1'b0, 32'h0, '0, 1'b0, "zw_rd_0");
    access(1, 1'b1, 1'b0, 32'h4, '0, 1'b0, "zw_rd_4");
    access(1, 1'b1, 1'b0, 32'h8, '0, 1'b0, "zw_rd_8");

    access(0, 1'b1, 1'b0, 32'h14, '0, 1'b0, "pre_err_rd");
    access(0, 1'b1, 1'b0, 32'h22, '0, 1'b0, "err_misaligned");
    access(0, 1'b1, 1'b0, 32'(4 * DEPTH), '0, 1'b0, "err_range");
    access(0, 1'b1, 1'b1, 32'h30, 32'hFFFF_0000, 1'b0, "err_rdwr");
    access(0, 1'b1, 1'b0, 32'h30, '0, 1'b0, "rd_30_intact");

    access(0, 1'b1, 1'b0, 32'h40, '0, 1'b1, "busy_tamper");
    access(0, 1'b1, 1'b0, 32'h44, '0, 1'b0, "rd_44_intact");

    // Request held past MemReady: exactly one extra access from the IDLE cycle.
    begin
      logic exp_err;
      int   k;
      exp_err = model_access(0, 1'b1, 1'b0, 32'h8, '0);
      @(negedge clk);
      rd_i[0] = 1'b1; adr_i[0] = 32'h8;
      @(posedge clk); #1;
      k = 0;
      while (!rdy_o[0] && k < 20) begin @(posedge clk); #1; k++; end
      check("held_first_latency", 32'(k), 32'd3);
      check("held_first_rdata", rdat_o[0], mdl_rd[0]);
      @(posedge clk); #1;
      check("held_resp_to_idle", {30'd0, rdy_o[0], busy_o[0]}, 32'd0);
      exp_err = model_access(0, 1'b1, 1'b0, 32'h8, '0);
      @(posedge clk); #1;
      check("held_second_accept", 32'(busy_o[0]), 32'd1);
      rd_i[0] = 1'b0;
      k = 0;
      while (!rdy_o[0] && k < 20) begin @(posedge clk); #1; k++; end
      check("held_second_latency", 32'(k), 32'd3);
      check("held_second_err", 32'(err_o[0]), 32'(exp_err));
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("held_no_third", {30'd0, rdy_o[0], busy_o[0]}, 32'd0);
    end

    // Random traffic over the initialised region plus occasional bad addresses.
    for (int n = 0; n < 80; n++) begin
      int          d;
      int          sel;
      bit          rd;
      bit          wr;
      logic [31:0] adr;
      d   = n % 2;
      sel = int'($urandom_range(0, 9));
      adr = 32'($urandom_range(0, 31)) << 2;
      if (sel == 0) adr = adr | 32'($urandom_range(1, 3));
      if (sel == 1) adr = 32'(4 * DEPTH) + (32'($urandom_range(0, 64)) << 2);
      rd  = sel == 2 || ($urandom_range(0, 1) == 1);
      wr  = sel == 2 || !rd;
      access(d, rd, wr, adr, $urandom, 1'b0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
